// File: rtl/sram_arbiter_pkg.sv
// Shared constants for the two-requester SRAM arbiter.
package sram_arbiter_pkg;

  localparam int unsigned NUM_REQ = 2;

  // Last-grant pointer after reset; 1 means requester 0 wins the first contention.
  localparam logic RST_LAST_GNT = 1'b1;

  // FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  // Requester index to one-hot requester mask.
  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grant, registered last-grant pointer.
module rr_arbiter2
  import sram_arbiter_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_valid_i,
  input  logic               accept_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               gnt_idx_o
);

  logic last_q;
  logic last_d;

  // Pick the single valid requester, or the one not granted last on contention.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = 1'b0;
    case (req_valid_i)
      2'b01: begin
        gnt_o     = 2'b01;
        gnt_idx_o = 1'b0;
      end
      2'b10: begin
        gnt_o     = 2'b10;
        gnt_idx_o = 1'b1;
      end
      2'b11: begin
        gnt_idx_o = ~last_q;
        gnt_o     = idx_to_onehot(~last_q);
      end
      default: begin
        gnt_o     = '0;
        gnt_idx_o = 1'b0;
      end
    endcase
  end

  // Pointer moves only when the grant is actually taken.
  always_comb begin
    last_d = last_q;
    if (accept_i) begin
      last_d = gnt_idx_o;
    end
  end

  // Last-grant pointer register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= RST_LAST_GNT;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin front end serialising two requesters onto one single-port SRAM.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0]            req_we,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0]   req_wdata,
  output logic [1:0]            rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  sram_en,
  output logic                  sram_we,
  output logic [ADDR_W-1:0]     sram_addr,
  output logic [DATA_W-1:0]     sram_wdata,
  input  logic [DATA_W-1:0]     sram_rdata
);

  logic [1:0]        state_q, state_d;
  logic              gidx_q, gidx_d;
  logic              sram_en_q, sram_en_d;
  logic              sram_we_q, sram_we_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [DATA_W-1:0] sram_wdata_q, sram_wdata_d;
  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic [1:0]        gnt;
  logic              win_idx;
  logic              accept;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  rr_arbiter2 u_rr_arbiter2 (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .accept_i    (accept),
    .gnt_o       (gnt),
    .gnt_idx_o   (win_idx)
  );

  // Ready only in IDLE, and held low while reset is asserted.
  always_comb begin
    req_ready = '0;
    if ((state_q == ST_IDLE) && !rst) begin
      req_ready = gnt;
    end
    accept = |(req_valid & req_ready);
  end

  // Select the winning requester's command fields.
  always_comb begin
    sel_we    = win_idx ? req_we[1] : req_we[0];
    sel_addr  = win_idx ? req_addr[ADDR_W +: ADDR_W] : req_addr[0 +: ADDR_W];
    sel_wdata = win_idx ? req_wdata[DATA_W +: DATA_W] : req_wdata[0 +: DATA_W];
  end

  // FSM next state; SRAM registers double as the command latch and are zero when idle.
  always_comb begin
    state_d      = state_q;
    gidx_d       = gidx_q;
    sram_en_d    = 1'b0;
    sram_we_d    = 1'b0;
    sram_addr_d  = '0;
    sram_wdata_d = '0;
    rsp_valid_d  = '0;
    rsp_rdata_d  = rsp_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d      = ST_CMD;
          gidx_d       = win_idx;
          sram_en_d    = 1'b1;
          sram_we_d    = sel_we;
          sram_addr_d  = sel_addr;
          sram_wdata_d = sel_wdata;
        end
      end
      ST_CMD: begin
        state_d = sram_we_q ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT: begin
        rsp_rdata_d = sram_rdata;
        rsp_valid_d = idx_to_onehot(gidx_q);
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, command and response registers; reset abandons any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      gidx_q       <= 1'b0;
      sram_en_q    <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      gidx_q       <= gidx_d;
      sram_en_q    <= sram_en_d;
      sram_we_q    <= sram_we_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
    end
  end

  assign sram_en    = sram_en_q;
  assign sram_we    = sram_we_q;
  assign sram_addr  = sram_addr_q;
  assign sram_wdata = sram_wdata_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed, table-driven bench for sram_arbiter with a behavioural SRAM model.
module tb_sram_arbiter;

  logic       clk;
  logic       rst;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [1:0] req_we;
  logic [7:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0] rsp_valid;
  logic [7:0] rsp_rdata;
  logic       sram_en;
  logic       sram_we;
  logic [3:0] sram_addr;
  logic [7:0] sram_wdata;
  logic [7:0] sram_rdata;

  logic       mem_init;
  logic [7:0] mem [16];

  int vec_cnt;
  int miss_cnt;

  typedef struct {
    logic [1:0] valid;
    logic [1:0] we;
    logic [3:0] a0;
    logic [3:0] a1;
    logic [7:0] w0;
    logic [7:0] w1;
    logic [1:0] rdy;
    logic       en;
    logic       swe;
    logic [3:0] addr;
    logic [7:0] wd;
    logic [1:0] rsp;
    logic [7:0] rd;
  } vec_t;

  vec_t tbl [30];

  sram_arbiter #(
    .ADDR_W (4),
    .DATA_W (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: read data only meaningful the cycle after a read strobe, junk otherwise.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'h10 + 8'(i);
      sram_rdata <= 8'hEE;
    end else if (sram_en && sram_we) begin
      mem[sram_addr] <= sram_wdata;
      sram_rdata <= 8'hEE;
    end else if (sram_en) begin
      sram_rdata <= mem[sram_addr];
    end else begin
      sram_rdata <= 8'hEE;
    end
  end

  function automatic vec_t mk(input logic [1:0] valid, input logic [1:0] we,
                              input logic [3:0] a0, input logic [3:0] a1,
                              input logic [7:0] w0, input logic [7:0] w1,
                              input logic [1:0] rdy, input logic en, input logic swe,
                              input logic [3:0] addr, input logic [7:0] wd,
                              input logic [1:0] rsp, input logic [7:0] rd);
    vec_t v;
    v.valid = valid; v.we = we; v.a0 = a0; v.a1 = a1; v.w0 = w0; v.w1 = w1;
    v.rdy = rdy; v.en = en; v.swe = swe; v.addr = addr; v.wd = wd; v.rsp = rsp; v.rd = rd;
    return v;
  endfunction

  function automatic logic [25:0] pk(input logic [1:0] rdy, input logic en, input logic swe,
                                     input logic [3:0] addr, input logic [7:0] wd,
                                     input logic [1:0] rsp, input logic [7:0] rd);
    return {rdy, en, swe, addr, wd, rsp, rd};
  endfunction

  // One cycle: drive inputs 1 time unit after the edge, leave 1 more for settling.
  task automatic step(input logic r, input logic [1:0] valid, input logic [1:0] we,
                      input logic [3:0] a0, input logic [3:0] a1,
                      input logic [7:0] w0, input logic [7:0] w1);
    @(posedge clk);
    #1;
    rst       = r;
    req_valid = valid;
    req_we    = we;
    req_addr  = {a1, a0};
    req_wdata = {w1, w0};
    #1;
  endtask

  task automatic check(input string name, input logic [25:0] exp);
    logic [25:0] act;
    act = {req_ready, sram_en, sram_we, sram_addr, sram_wdata, rsp_valid, rsp_rdata};
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got ready=%b en=%b we=%b addr=%h wdata=%h rsp=%b rdata=%h ; want ready=%b en=%b we=%b addr=%h wdata=%h rsp=%b rdata=%h",
               name, act[25:24], act[23], act[22], act[21:18], act[17:10], act[9:8], act[7:0],
               exp[25:24], exp[23], exp[22], exp[21:18], exp[17:10], exp[9:8], exp[7:0]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_cnt   = 0;
    miss_cnt  = 0;
    rst       = 1'b1;
    mem_init  = 1'b1;
    req_valid = 2'b11;
    req_we    = 2'b00;
    req_addr  = '0;
    req_wdata = '0;

    // Write r0, read r0, r1 write/read back-to-back, then 6 contended reads (addr 1 / addr 2).
    tbl[0]  = mk(2'b01, 2'b01, 4'h3, 4'h0, 8'hA5, 8'h00, 2'b01, 0, 0, 4'h0, 8'h00, 2'b00, 8'h00);
    tbl[1]  = mk(2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00, 2'b00, 1, 1, 4'h3, 8'hA5, 2'b00, 8'h00);
    tbl[2]  = mk(2'b01, 2'b00, 4'h3, 4'h0, 8'h00, 8'h00, 2'b01, 0, 0, 4'h0, 8'h00, 2'b00, 8'h00);
    tbl[3]  = mk(2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00, 2'b00, 1, 0, 4'h3, 8'h00, 2'b00, 8'h00);
    tbl[4]  = mk(2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00, 2'b00, 0, 0, 4'h0, 8'h00, 2'b00, 8'h00);
    tbl[5]  = mk(2'b10, 2'b10, 4'h0, 4'hF, 8'h00, 8'h3C, 2'b10, 0, 0, 4'h0, 8'h00, 2'b01, 8'hA5);
    tbl[6]  = mk(2'b10, 2'b00, 4'h0, 4'hF, 8'h00, 8'h00, 2'b00, 1, 1, 4'hF, 8'h3C, 2'b00, 8'hA5);
    tbl[7]  = mk(2'b10, 2'b00, 4'h0, 4'hF, 8'h00, 8'h00, 2'b10, 0, 0, 4'h0, 8'h00, 2'b00, 8'hA5);
    tbl[8]  = mk(2'b11, 2'b00, 4'h1, 4'h2, 8'h00, 8'h00, 2'b00, 1, 0, 4'hF, 8'h00, 2'b00, 8'hA5);
    tbl[9]  = mk(2'b11, 2'b00, 4'h1, 4'h2, 8'h00, 8'h00, 2'b00, 0, 0, 4'h0, 8'h00, 2'b00, 8'hA5);
    tbl[10] = mk(2'b11, 2'b00, 4'h1, 4'h2, 8'h00, 8'h00, 2'b01, 0, 0, 4'h0, 8'h00, 2'b10, 8'h3C);
    tbl[11] = mk(2'b11, 2'b00, 4'h1, 4'h2, 8'h00, 8'h00, 2'b00, 1, 0, 4'h1, 8'h00, 2'b00, 8'h3C);
    tbl[12] = mk(2'b11, 2'b00, 4'h1, 4'h2, 8'h00, 8'h00, 2'b00, 0, 0, 4'h0, 8'h00, 2'b00, 8'h3C);
    tbl[13] = mk(2'b11, 2'b00, 4'h1, 4'h2, 8'h00, 8'h00, 2'b10, 0, 0, 4'h0, 8'h00, 2'b01, 8'h11);
    tbl[14] = mk(2'b11, 2'b00, 4'h1, 4'h2, 8'h00, 8'h00, 2'b00, 1, 0, 4'h2, 8'h00, 2'b00, 8'h11);
    tbl[15] = mk(2'b11, 2'b00, 4'h1, 4'h2, 8'h00, 8'h00, 2'b00, 0, 0, 4'h0, 8'h00, 2'b00, 8'h11);
    tbl[16] = mk(2'b11, 2'b00, 4'h1, 4'h2, 8'h00, 8'h00, 2'b01, 0, 0, 4'h0, 8'h00, 2'b10, 8'h12);
    tbl[17] = mk(2'b11, 2'b00, 4'h1, 4'h2, 8'h00, 8'h00, 2'b00, 1, 0, 4'h1, 8'h00, 2'b00, 8'h12);
    tbl[18] = mk(2'b11, 2'b00, 4'h1, 4'h2, 8'h00, 8'h00, 2'b00, 0, 0, 4'h0, 8'h00, 2'b00, 8'h12);
    tbl[19] = mk(2'b11, 2'b00, 4'h1, 4'h2, 8'h00, 8'h00, 2'b10, 0, 0, 4'h0, 8'h00, 2'b01, 8'h11);
    tbl[20] = mk(2'b11, 2'b00, 4'h1, 4'h2, 8'h00, 8'h00, 2'b00, 1, 0, 4'h2, 8'h00, 2'b00, 8'h11);
    tbl[21] = mk(2'b11, 2'b00, 4'h1, 4'h2, 8'h00, 8'h00, 2'b00, 0, 0, 4'h0, 8'h00, 2'b00, 8'h11);
    tbl[22] = mk(2'b11, 2'b00, 4'h1, 4'h2, 8'h00, 8'h00, 2'b01, 0, 0, 4'h0, 8'h00, 2'b10, 8'h12);
    tbl[23] = mk(2'b11, 2'b00, 4'h1, 4'h2, 8'h00, 8'h00, 2'b00, 1, 0, 4'h1, 8'h00, 2'b00, 8'h12);
    tbl[24] = mk(2'b11, 2'b00, 4'h1, 4'h2, 8'h00, 8'h00, 2'b00, 0, 0, 4'h0, 8'h00, 2'b00, 8'h12);
    tbl[25] = mk(2'b11, 2'b00, 4'h1, 4'h2, 8'h00, 8'h00, 2'b10, 0, 0, 4'h0, 8'h00, 2'b01, 8'h11);
    tbl[26] = mk(2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00, 2'b00, 1, 0, 4'h2, 8'h00, 2'b00, 8'h11);
    tbl[27] = mk(2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00, 2'b00, 0, 0, 4'h0, 8'h00, 2'b00, 8'h11);
    tbl[28] = mk(2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00, 2'b00, 0, 0, 4'h0, 8'h00, 2'b10, 8'h12);
    tbl[29] = mk(2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00, 2'b00, 0, 0, 4'h0, 8'h00, 2'b00, 8'h12);

    // Reset held with both requesters valid.
    @(posedge clk);
    #1 mem_init = 1'b0;
    @(posedge clk);
    #2 check("reset_hold", pk(2'b00, 0, 0, 4'h0, 8'h00, 2'b00, 8'h00));

    // Release: requester 0 wins the first contention, then both withdraw before the edge.
    step(1'b0, 2'b11, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00);
    check("reset_release_grant", pk(2'b01, 0, 0, 4'h0, 8'h00, 2'b00, 8'h00));
    #1 req_valid = 2'b00;

    for (int i = 0; i < 30; i++) begin
      step(1'b0, tbl[i].valid, tbl[i].we, tbl[i].a0, tbl[i].a1, tbl[i].w0, tbl[i].w1);
      check($sformatf("vec%0d", i),
            pk(tbl[i].rdy, tbl[i].en, tbl[i].swe, tbl[i].addr, tbl[i].wd, tbl[i].rsp, tbl[i].rd));
    end

    // Abort: reset during WAIT of a read of addr 3 by requester 0.
    step(1'b0, 2'b01, 2'b00, 4'h3, 4'h0, 8'h00, 8'h00);
    check("abort_hs", pk(2'b01, 0, 0, 4'h0, 8'h00, 2'b00, 8'h12));
    step(1'b0, 2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00);
    check("abort_cmd", pk(2'b00, 1, 0, 4'h3, 8'h00, 2'b00, 8'h12));
    step(1'b1, 2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00);
    check("abort_rst_wait", pk(2'b00, 0, 0, 4'h0, 8'h00, 2'b00, 8'h00));
    step(1'b1, 2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00);
    check("abort_rst_hold", pk(2'b00, 0, 0, 4'h0, 8'h00, 2'b00, 8'h00));
    step(1'b0, 2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00);
    check("abort_no_rsp0", pk(2'b00, 0, 0, 4'h0, 8'h00, 2'b00, 8'h00));
    step(1'b0, 2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00);
    check("abort_no_rsp1", pk(2'b00, 0, 0, 4'h0, 8'h00, 2'b00, 8'h00));
    step(1'b0, 2'b01, 2'b00, 4'h3, 4'h0, 8'h00, 8'h00);
    check("abort_reread_hs", pk(2'b01, 0, 0, 4'h0, 8'h00, 2'b00, 8'h00));
    step(1'b0, 2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00);
    check("abort_reread_cmd", pk(2'b00, 1, 0, 4'h3, 8'h00, 2'b00, 8'h00));
    step(1'b0, 2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00);
    check("abort_reread_wait", pk(2'b00, 0, 0, 4'h0, 8'h00, 2'b00, 8'h00));
    step(1'b0, 2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00);
    check("abort_reread_rsp", pk(2'b00, 0, 0, 4'h0, 8'h00, 2'b01, 8'hA5));

    // Withdrawal: requester 1 pulses valid during CMD of a requester-0 write.
    step(1'b0, 2'b01, 2'b01, 4'h5, 4'h0, 8'h77, 8'h00);
    check("wd_hs", pk(2'b01, 0, 0, 4'h0, 8'h00, 2'b00, 8'hA5));
    step(1'b0, 2'b10, 2'b00, 4'h0, 4'h9, 8'h00, 8'h00);
    check("wd_pulse_in_cmd", pk(2'b00, 1, 1, 4'h5, 8'h77, 2'b00, 8'hA5));
    step(1'b0, 2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00);
    check("wd_no_access0", pk(2'b00, 0, 0, 4'h0, 8'h00, 2'b00, 8'hA5));
    step(1'b0, 2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00);
    check("wd_no_access1", pk(2'b00, 0, 0, 4'h0, 8'h00, 2'b00, 8'hA5));
    // Pointer still says requester 0 was last, so requester 1 wins now.
    step(1'b0, 2'b11, 2'b00, 4'h5, 4'h9, 8'h00, 8'h00);
    check("wd_ptr_unchanged", pk(2'b10, 0, 0, 4'h0, 8'h00, 2'b00, 8'hA5));
    step(1'b0, 2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00);
    check("wd_read_cmd", pk(2'b00, 1, 0, 4'h9, 8'h00, 2'b00, 8'hA5));
    step(1'b0, 2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00);
    check("wd_read_wait", pk(2'b00, 0, 0, 4'h0, 8'h00, 2'b00, 8'hA5));
    step(1'b0, 2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00);
    check("wd_read_rsp", pk(2'b00, 0, 0, 4'h0, 8'h00, 2'b10, 8'h19));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
